lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl.sv | 159 +++++++++++++++
 tb/tb_lsu_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: sequences CPU byte/half/word loads and stores onto a word-wide data memory.
// Define LSU_ERR_CHK_EN to enable alignment and range checking with rsp_err reporting.
module lsu_ctrl #(
    parameter int ADDR_W   = 14,
    parameter int DM_BYTES = 12288
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_sign,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_din,
    output logic              dm_we,
    input  logic [31:0]       dm_dout
);

    // state     | meaning
    // ST_IDLE   | ready for a request
    // ST_LOAD   | read word, extract and extend the addressed lane
    // ST_RMW_RD | read word into the merge register for a sub-word store
    // ST_WRITE  | single-cycle data-memory write
    // ST_RESP   | one-cycle response pulse
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RMW_RD,
        ST_WRITE,
        ST_RESP
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              sign_q;
    logic [31:0]       wdata_q;
    logic [31:0]       merge_q;
    logic              rsp_valid_q;
    logic [31:0]       rsp_rdata_q;
    logic              rsp_err_q;

    logic              req_err;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       load_d;
    logic [31:0]       din_d;

`ifdef LSU_ERR_CHK_EN
    localparam logic [ADDR_W:0] DM_LIMIT = (ADDR_W+1)'(DM_BYTES);
    logic [ADDR_W:0] req_word_last;

    assign req_word_last = {1'b0, req_addr[ADDR_W-1:2], 2'b11};

    always_comb begin
        req_err = (req_word_last >= DM_LIMIT);
        case (req_size)
            2'b01:   if (req_addr[0]) req_err = 1'b1;
            2'b10:   if (req_addr[1:0] != 2'b00) req_err = 1'b1;
            2'b11:   req_err = 1'b1;
            default: ;
        endcase
    end
`else
    assign req_err = 1'b0;
`endif

    // Without checking, size 11 falls into the word paths and half lanes use addr[1] only.
    always_comb begin
        ld_byte = dm_dout[{addr_q[1:0], 3'b000} +: 8];
        ld_half = dm_dout[{addr_q[1], 4'b0000} +: 16];
        case (size_q)
            2'b00:   load_d = {{24{sign_q & ld_byte[7]}}, ld_byte};
            2'b01:   load_d = {{16{sign_q & ld_half[15]}}, ld_half};
            default: load_d = dm_dout;
        endcase
    end

    always_comb begin
        din_d = merge_q;
        case (size_q)
            2'b00:   din_d[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'b01:   din_d[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: din_d = wdata_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
            merge_q     <= 32'h0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        size_q  <= req_size;
                        sign_q  <= req_sign;
                        wdata_q <= req_wdata;
                        if (req_err) begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= 32'h0;
                            rsp_err_q   <= 1'b1;
                        end else if (!req_we) begin
                            state_q <= ST_LOAD;
                        end else if (req_size[1]) begin
                            state_q <= ST_WRITE;
                        end else begin
                            state_q <= ST_RMW_RD;
                        end
                    end
                end
                ST_LOAD: begin
                    state_q     <= ST_RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= load_d;
                    rsp_err_q   <= 1'b0;
                end
                ST_RMW_RD: begin
                    state_q <= ST_WRITE;
                    merge_q <= dm_dout;
                end
                ST_WRITE: begin
                    state_q     <= ST_RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= 32'h0;
                    rsp_err_q   <= 1'b0;
                end
                ST_RESP: begin
                    state_q     <= ST_IDLE;
                    rsp_rdata_q <= 32'h0;
                    rsp_err_q   <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign dm_addr   = {addr_q[ADDR_W-1:2], 2'b00};
    assign dm_din    = din_d;
    // Gated by rst_n so a reset landing on the WRITE cycle suppresses the write.
    assign dm_we     = rst_n && (state_q == ST_WRITE);

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed and randomized checks of lsu_ctrl against a byte-array reference model.
module tb_lsu_ctrl;
    localparam int AW    = 14;
    localparam int DMB   = 12288;
    localparam int WORDS = DMB / 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, req_we, req_sign;
    logic [1:0]    req_size;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid, rsp_err, dm_we;
    logic [31:0]   rsp_rdata, dm_din, dm_dout;
    logic [AW-1:0] dm_addr;

    logic [31:0]   dm_mem [WORDS];
    bit            mem_init_done = 1'b0;
    int            we_cnt = 0;
    int            rsp_cnt = 0;
    logic [7:0]    ref_b [DMB];
    int            total = 0;
    int            bad = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.ADDR_W(AW), .DM_BYTES(DMB)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_sign(req_sign), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .dm_addr(dm_addr), .dm_din(dm_din), .dm_we(dm_we), .dm_dout(dm_dout)
    );

    function automatic logic [31:0] seed_word(input int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'hA5A5_5A5A;
    endfunction

    function automatic logic [31:0] ref_word(input int i);
        return {ref_b[4*i+3], ref_b[4*i+2], ref_b[4*i+1], ref_b[4*i]};
    endfunction

    assign dm_dout = (int'(dm_addr[AW-1:2]) < WORDS) ? dm_mem[dm_addr[AW-1:2]] : 32'h0;

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < WORDS; i++) dm_mem[i] <= seed_word(i);
            mem_init_done <= 1'b1;
        end else if (dm_we && int'(dm_addr[AW-1:2]) < WORDS) begin
            dm_mem[dm_addr[AW-1:2]] <= dm_din;
        end
        if (dm_we) we_cnt <= we_cnt + 1;
        if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
    end

    // Reference: memory is a byte array; each request is applied whole at acceptance.
    task automatic model(input logic we, input logic [1:0] size, input logic sign,
                         input logic [AW-1:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int lat, output int wes);
        int a, nb, base;
        logic [31:0] v;
        a = int'(addr);
        err = 1'b0;
`ifdef LSU_ERR_CHK_EN
        if (size == 2'b11 || (size == 2'b01 && a % 2 != 0) || (size == 2'b10 && a % 4 != 0) ||
            (a / 4) * 4 + 3 >= DMB)
            err = 1'b1;
`endif
        nb = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        base = (a / nb) * nb;
        rdata = 32'h0;
        lat = 1;
        wes = 0;
        if (!err) begin
            if (!we) begin
                v = 32'h0;
                for (int i = 0; i < nb; i++) v = v | (32'(ref_b[base+i]) << (8 * i));
                if (sign && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
                rdata = v;
                lat = 2;
            end else begin
                for (int i = 0; i < nb; i++) ref_b[base+i] = wdata[8*i +: 8];
                lat = (nb == 4) ? 2 : 3;
                wes = 1;
            end
        end
    endtask

    task automatic issue(input logic we, input logic [1:0] size, input logic sign,
                         input logic [AW-1:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int lat,
                         output int wes, output bit to);
        int w;
        int we0;
        to = 1'b0;
        req_we = we; req_size = size; req_sign = sign; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        w = 0;
        while (!req_ready && w < 20) begin @(negedge clk); w++; end
        if (!req_ready) to = 1'b1;
        we0 = we_cnt;
        @(negedge clk);
        req_valid = 1'b0;
        req_we = 1'($urandom); req_size = 2'($urandom); req_addr = AW'($urandom); req_wdata = $urandom;
        lat = 1;
        while (!rsp_valid && lat < 10) begin @(negedge clk); lat++; end
        if (!rsp_valid) to = 1'b1;
        rdata = rsp_rdata;
        err = rsp_err;
        @(negedge clk);
        wes = we_cnt - we0;
    endtask

    task automatic gen(output logic we, output logic [1:0] size, output logic sign,
                       output logic [AW-1:0] addr, output logic [31:0] wdata);
        we = 1'($urandom); size = 2'($urandom); sign = 1'($urandom); wdata = $urandom;
`ifdef LSU_ERR_CHK_EN
        addr = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, DMB - 1));
`else
        addr = AW'($urandom_range(0, DMB - 1));
`endif
        if ($urandom_range(0, 1) == 1) begin
            if (size == 2'b01) addr[0] = 1'b0;
            if (size[1]) addr[1:0] = 2'b00;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_sign = 1'b0;
        req_addr = 14'h0040; req_wdata = 32'h1111_2222;
        repeat (3) @(negedge clk);
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata); end
        total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
        total++; if (dm_we !== 1'b0) begin bad++; $display("FAIL reset_dm_we got=%b exp=0", dm_we); end
        req_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
        @(negedge clk);
        total++; if (we_cnt != 0) begin bad++; $display("FAIL reset_no_write got=%0d exp=0", we_cnt); end
    endtask

    task automatic test_directed();
        logic [31:0] rd, erd; logic er, eer; int lat, wes, elat, ewes; bit to;
        model(1'b1, 2'b10, 1'b0, 14'h0010, 32'hDEAD_BEEF, erd, eer, elat, ewes);
        issue(1'b1, 2'b10, 1'b0, 14'h0010, 32'hDEAD_BEEF, rd, er, lat, wes, to);
        total++; if (to) begin bad++; $display("FAIL sw_timeout got=timeout exp=rsp"); end
        total++; if (wes != 1) begin bad++; $display("FAIL sw_we_count got=%0d exp=1", wes); end
        total++; if (lat != 2) begin bad++; $display("FAIL sw_latency got=%0d exp=2", lat); end
        model(1'b0, 2'b10, 1'b0, 14'h0010, 32'h0, erd, eer, elat, ewes);
        issue(1'b0, 2'b10, 1'b0, 14'h0010, 32'h0, rd, er, lat, wes, to);
        total++; if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL lw_data got=%h exp=deadbeef", rd); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL lw_err got=%b exp=0", er); end
        total++; if (lat != 2) begin bad++; $display("FAIL lw_latency got=%0d exp=2", lat); end
        model(1'b1, 2'b00, 1'b0, 14'h0012, 32'hFFFF_FF5A, erd, eer, elat, ewes);
        issue(1'b1, 2'b00, 1'b0, 14'h0012, 32'hFFFF_FF5A, rd, er, lat, wes, to);
        total++; if (lat != 3) begin bad++; $display("FAIL sb_latency got=%0d exp=3", lat); end
        total++; if (wes != 1) begin bad++; $display("FAIL sb_we_count got=%0d exp=1", wes); end
        model(1'b0, 2'b10, 1'b0, 14'h0010, 32'h0, erd, eer, elat, ewes);
        issue(1'b0, 2'b10, 1'b0, 14'h0010, 32'h0, rd, er, lat, wes, to);
        total++; if (rd !== 32'hDE5A_BEEF) begin bad++; $display("FAIL sb_merge got=%h exp=de5abeef", rd); end
        issue(1'b0, 2'b00, 1'b1, 14'h0013, 32'h0, rd, er, lat, wes, to);
        total++; if (rd !== 32'hFFFF_FFDE) begin bad++; $display("FAIL lb_sign got=%h exp=ffffffde", rd); end
        issue(1'b0, 2'b00, 1'b0, 14'h0013, 32'h0, rd, er, lat, wes, to);
        total++; if (rd !== 32'h0000_00DE) begin bad++; $display("FAIL lbu got=%h exp=000000de", rd); end
        issue(1'b0, 2'b01, 1'b1, 14'h0012, 32'h0, rd, er, lat, wes, to);
        total++; if (rd !== 32'hFFFF_DE5A) begin bad++; $display("FAIL lh_sign got=%h exp=ffffde5a", rd); end
    endtask

    task automatic test_errors();
        logic [AW-1:0] addrs [6];
        logic [1:0] sizes [6];
        logic wes_v [6];
        logic [31:0] rd, erd; logic er, eer; int lat, wes, elat, ewes; bit to;
        addrs = '{14'h0011, 14'h2FFE, 14'h0013, 14'h0020, 14'h2FFC, 14'h2FFD};
        sizes = '{2'b10, 2'b10, 2'b01, 2'b11, 2'b10, 2'b00};
        wes_v = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 6; k++) begin
            model(wes_v[k], sizes[k], 1'b1, addrs[k], 32'hCAFE_F00D, erd, eer, elat, ewes);
            issue(wes_v[k], sizes[k], 1'b1, addrs[k], 32'hCAFE_F00D, rd, er, lat, wes, to);
            total++; if (to) begin bad++; $display("FAIL err_timeout k=%0d got=timeout exp=rsp", k); end
            total++; if (er !== eer) begin bad++; $display("FAIL err_flag k=%0d got=%b exp=%b", k, er, eer); end
            total++; if (rd !== erd) begin bad++; $display("FAIL err_rdata k=%0d got=%h exp=%h", k, rd, erd); end
            total++; if (lat != elat) begin bad++; $display("FAIL err_latency k=%0d got=%0d exp=%0d", k, lat, elat); end
            total++; if (wes != ewes) begin bad++; $display("FAIL err_we k=%0d got=%0d exp=%0d", k, wes, ewes); end
        end
`ifdef LSU_ERR_CHK_EN
        issue(1'b0, 2'b00, 1'b0, 14'h3000, 32'h0, rd, er, lat, wes, to);
        total++; if (er !== 1'b1 || lat != 1) begin bad++; $display("FAIL err_range got=err%b/lat%0d exp=err1/lat1", er, lat); end
`endif
        total++;
        if (dm_mem[WORDS-1] !== ref_word(WORDS - 1)) begin
            bad++; $display("FAIL err_mem_top got=%h exp=%h", dm_mem[WORDS-1], ref_word(WORDS - 1));
        end
    endtask

    task automatic test_reset_in_write();
        int w, we0, rsp0;
        we0 = we_cnt; rsp0 = rsp_cnt;
        req_we = 1'b1; req_size = 2'b01; req_sign = 1'b0; req_addr = 14'h0010; req_wdata = 32'h0000_7777;
        req_valid = 1'b1;
        w = 0;
        while (!req_ready && w < 20) begin @(negedge clk); w++; end
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        total++; if (dm_we !== 1'b1) begin bad++; $display("FAIL rstw_reached got=%b exp=1", dm_we); end
        rst_n = 1'b0;
        #1;
        total++; if (dm_we !== 1'b0) begin bad++; $display("FAIL rstw_we_gated got=%b exp=0", dm_we); end
        @(negedge clk);
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rstw_rsp got=%b exp=0", rsp_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rstw_ready got=%b exp=1", req_ready); end
        @(negedge clk);
        total++; if (we_cnt != we0) begin bad++; $display("FAIL rstw_writes got=%0d exp=%0d", we_cnt, we0); end
        total++; if (rsp_cnt != rsp0) begin bad++; $display("FAIL rstw_rsps got=%0d exp=%0d", rsp_cnt, rsp0); end
        total++; if (dm_mem[4] !== ref_word(4)) begin bad++; $display("FAIL rstw_mem got=%h exp=%h", dm_mem[4], ref_word(4)); end
    endtask

    task automatic test_random();
        logic we, sign, er, eer; logic [1:0] size; logic [AW-1:0] addr; logic [31:0] wdata, rd, erd;
        int lat, wes, elat, ewes; bit to;
        for (int k = 0; k < 60; k++) begin
            gen(we, size, sign, addr, wdata);
            model(we, size, sign, addr, wdata, erd, eer, elat, ewes);
            issue(we, size, sign, addr, wdata, rd, er, lat, wes, to);
            total++; if (to) begin bad++; $display("FAIL rnd_timeout k=%0d got=timeout exp=rsp", k); end
            total++; if (rd !== erd) begin bad++; $display("FAIL rnd_rdata k=%0d a=%h s=%0d got=%h exp=%h", k, addr, size, rd, erd); end
            total++; if (er !== eer) begin bad++; $display("FAIL rnd_err k=%0d got=%b exp=%b", k, er, eer); end
            total++; if (lat != elat) begin bad++; $display("FAIL rnd_latency k=%0d got=%0d exp=%0d", k, lat, elat); end
            total++; if (wes != ewes) begin bad++; $display("FAIL rnd_we k=%0d got=%0d exp=%0d", k, wes, ewes); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_rd_q [$];
        logic        exp_err_q [$];
        int          exp_lat_q [$];
        int          acc_cyc_q [$];
        logic we, sign, eer; logic [1:0] size; logic [AW-1:0] addr; logic [31:0] wdata, erd;
        int elat, ewes, acc_c;
        int n_acc = 0, n_rsp = 0, cyc = 0, last_rsp = -1;
        bit need_new = 1'b1;
        while ((n_acc < 24 || n_rsp < n_acc) && cyc < 500) begin
            if (need_new) begin
                if (n_acc < 24) begin
                    gen(we, size, sign, addr, wdata);
                    req_we = we; req_size = size; req_sign = sign; req_addr = addr; req_wdata = wdata;
                    req_valid = 1'b1;
                end else begin
                    req_valid = 1'b0;
                end
                need_new = 1'b0;
            end
            if (rsp_valid === 1'b1) begin
                n_rsp++;
                last_rsp = cyc;
                total++;
                if (req_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_in_rsp cyc=%0d got=%b exp=0", cyc, req_ready); end
                total++;
                if (exp_rd_q.size() == 0) begin
                    bad++; $display("FAIL b2b_extra_rsp cyc=%0d got=rsp exp=none", cyc);
                end else begin
                    erd = exp_rd_q.pop_front(); eer = exp_err_q.pop_front();
                    elat = exp_lat_q.pop_front(); acc_c = acc_cyc_q.pop_front();
                    if (rsp_rdata !== erd) begin bad++; $display("FAIL b2b_rdata cyc=%0d got=%h exp=%h", cyc, rsp_rdata, erd); end
                    total++;
                    if (rsp_err !== eer) begin bad++; $display("FAIL b2b_err cyc=%0d got=%b exp=%b", cyc, rsp_err, eer); end
                    total++;
                    if (cyc - acc_c != elat) begin bad++; $display("FAIL b2b_latency cyc=%0d got=%0d exp=%0d", cyc, cyc - acc_c, elat); end
                end
            end
            if (req_valid && req_ready) begin
                if (n_acc > 0) begin
                    total++;
                    if (cyc != last_rsp + 1) begin bad++; $display("FAIL b2b_accept_gap cyc=%0d got=%0d exp=%0d", cyc, cyc, last_rsp + 1); end
                end
                model(req_we, req_size, req_sign, req_addr, req_wdata, erd, eer, elat, ewes);
                exp_rd_q.push_back(erd); exp_err_q.push_back(eer);
                exp_lat_q.push_back(elat); acc_cyc_q.push_back(cyc);
                n_acc++;
                need_new = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        req_valid = 1'b0;
        total++;
        if (n_acc != 24 || n_rsp != n_acc) begin
            bad++; $display("FAIL b2b_counts got=acc%0d/rsp%0d exp=acc24/rsp24", n_acc, n_rsp);
        end
    endtask

    task automatic test_memory();
        int nbad = 0;
        int first = -1;
        for (int i = 0; i < WORDS; i++) begin
            if (dm_mem[i] !== ref_word(i)) begin
                nbad++;
                if (first < 0) first = i;
            end
        end
        total++;
        if (nbad != 0) begin
            bad++;
            $display("FAIL mem_sweep words=%0d first=%0d got=%h exp=%h", nbad, first, dm_mem[first], ref_word(first));
        end
    endtask

    initial begin
        logic [31:0] w;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_sign = 1'b0;
        req_addr = '0; req_wdata = 32'h0;
        for (int i = 0; i < WORDS; i++) begin
            w = seed_word(i);
            for (int k = 0; k < 4; k++) ref_b[4*i+k] = w[8*k +: 8];
        end
        test_reset();
        test_directed();
        test_errors();
        test_reset_in_write();
        test_random();
        test_back_to_back();
        test_memory();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
